// File: rtl/mult_r8_accum.sv
// Radix-8 sequential signed multiplier: consumes precomputed |A| multiples and
// accumulates one 3-bit digit of |B| per cycle, returning A*B via valid/ready.
module mult_r8_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [6:0]  iDat1X,
  input  logic [8:0]  iDat3X,
  input  logic [9:0]  iDat5X,
  input  logic [9:0]  iDat7X,
  input  logic        iNegative,
  input  logic [7:0]  iDatB,
  output logic        oValid,
  input  logic        iReady,
  output logic [15:0] oProduct
);

  localparam int unsigned SEL_W  = 13;
  localparam int unsigned ACC_W  = 15;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state;
  logic [6:0]         x1;
  logic [8:0]         x3;
  logic [9:0]         x5;
  logic [9:0]         x7;
  logic [7:0]         bmag;
  logic               sgn;
  logic [ACC_W-1:0]   acc;
  logic [1:0]         cnt;

  logic [7:0]         bmag_in;
  logic [2:0]         digit;
  logic [SEL_W-1:0]   sel;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_sum;
  logic [PROD_W-1:0]  mag_prod;

  // |B| as unsigned; -128 maps naturally to 8'h80
  assign bmag_in = iDatB[7] ? (~iDatB + 8'd1) : iDatB;

  // Current digit, its multiple, and the weighted addend
  always_comb begin
    digit    = 3'd0;
    sel      = '0;
    addend   = '0;
    case (cnt)
      2'd0:    digit = bmag[2:0];
      2'd1:    digit = bmag[5:3];
      default: digit = {1'b0, bmag[7:6]};
    endcase
    case (digit)
      3'd1:    sel = SEL_W'(x1);
      3'd2:    sel = SEL_W'(x1) << 1;
      3'd3:    sel = SEL_W'(x3);
      3'd4:    sel = SEL_W'(x1) << 2;
      3'd5:    sel = SEL_W'(x5);
      3'd6:    sel = SEL_W'(x3) << 1;
      3'd7:    sel = SEL_W'(x7);
      default: sel = '0;
    endcase
    // |A|*|B| <= 16256, so the top digit's shifted multiple never exceeds 15 bits
    case (cnt)
      2'd0:    addend = ACC_W'(sel);
      2'd1:    addend = ACC_W'(sel) << 3;
      default: addend = ACC_W'(sel) << 6;
    endcase
    acc_sum  = acc + addend;
    mag_prod = {1'b0, acc_sum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      oReady   <= 1'b1;
      oValid   <= 1'b0;
      oProduct <= '0;
      x1       <= '0;
      x3       <= '0;
      x5       <= '0;
      x7       <= '0;
      bmag     <= '0;
      sgn      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            x1     <= iDat1X;
            x3     <= iDat3X;
            x5     <= iDat5X;
            x7     <= iDat7X;
            bmag   <= bmag_in;
            sgn    <= iNegative ^ iDatB[7];
            acc    <= '0;
            cnt    <= '0;
            oReady <= 1'b0;
            state  <= ACC;
          end
        end
        ACC: begin
          acc <= acc_sum;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd2) begin
            // Negating a zero magnitude yields 0, so no -0 can appear
            oProduct <= sgn ? (PROD_W'(0) - mag_prod) : mag_prod;
            oValid   <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            oReady <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_r8_accum.sv
// Directed bench for mult_r8_accum: hand-computed products, handshake,
// operand stability, stall and mid-operation reset.
module tb_mult_r8_accum;

  logic        clk;
  logic        rst;
  logic        iValid;
  logic        oReady;
  logic [6:0]  iDat1X;
  logic [8:0]  iDat3X;
  logic [9:0]  iDat5X;
  logic [9:0]  iDat7X;
  logic        iNegative;
  logic [7:0]  iDatB;
  logic        oValid;
  logic        iReady;
  logic [15:0] oProduct;

  int checks = 0;
  int failures = 0;

  mult_r8_accum dut (
    .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady),
    .iDat1X(iDat1X), .iDat3X(iDat3X), .iDat5X(iDat5X), .iDat7X(iDat7X),
    .iNegative(iNegative), .iDatB(iDatB), .oValid(oValid), .iReady(iReady),
    .oProduct(oProduct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Upstream encoding: -128 arrives as magnitude 0 with the sign flag set
  task automatic drive_operands(input int a, input int b);
    int mag;
    mag = (a < 0) ? -a : a;
    if (a == -128) mag = 0;
    iDat1X    = 7'(mag);
    iDat3X    = 9'(3 * mag);
    iDat5X    = 10'(5 * mag);
    iDat7X    = 10'(7 * mag);
    iNegative = (a < 0);
    iDatB     = 8'(b);
  endtask

  task automatic start_op(input int a, input int b, input bit hold_valid);
    @(negedge clk);
    drive_operands(a, b);
    iValid = 1'b1;
    check("ready_before_accept", 32'(oReady), 32'd1);
    @(posedge clk);
    #1;
    if (!hold_valid) iValid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!oValid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    iReady = 1'b1;
    @(posedge clk);
    #1;
    iReady = 1'b0;
    check({tag, "_valid_drop"}, 32'(oValid), 32'd0);
    check({tag, "_ready_back"}, 32'(oReady), 32'd1);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input logic [15:0] exp, input bit full);
    int lat;
    start_op(a, b, 1'b0);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_product"}, 32'(oProduct), 32'(exp));
    if (full) begin
      check({tag, "_ready_low"}, 32'(oReady), 32'd0);
      consume(tag);
    end else begin
      iReady = 1'b1;
      @(posedge clk);
      #1;
      iReady = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int changes;
    logic [15:0] held;
    int a_set[11] = '{0, 1, -1, 3, -5, 7, 42, -64, 100, -127, 127};

    rst = 1'b1;
    iValid = 1'b0;
    iReady = 1'b0;
    drive_operands(0, 0);
    #2;
    check("reset_ready", 32'(oReady), 32'd1);
    check("reset_valid", 32'(oValid), 32'd0);
    check("reset_product", 32'(oProduct), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic", 5, 3, 16'd15, 1'b1);
    run_op("neg_a", -7, 9, 16'hFFC1, 1'b1);
    run_op("neg_b", 13, -111, 16'hFA5D, 1'b1);
    run_op("b_min", 127, -128, 16'hC080, 1'b1);
    run_op("both_neg", -127, -127, 16'h3F01, 1'b1);
    run_op("a_min_upstream", -128, 5, 16'h0000, 1'b1);
    run_op("zero_neg_a", -9, 0, 16'h0000, 1'b1);
    run_op("digit_all7", 1, 63, 16'd63, 1'b1);
    run_op("d2_is_2", -3, -128, 16'd384, 1'b1);

    // Held iValid with changing operands: only the first set is taken
    start_op(6, 7, 1'b1);
    drive_operands(100, 100);
    wait_valid(lat);
    check("hold_latency", 32'(lat), 32'd3);
    check("hold_product", 32'(oProduct), 32'd42);
    iValid = 1'b0;

    // Stall 10 cycles with iReady low
    held = oProduct;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (oProduct !== held || !oValid || oReady) changes++;
    end
    check("stall_stable", 32'(changes), 32'd0);
    check("stall_product", 32'(oProduct), 32'd42);
    consume("stall");

    // Reset asserted in the second ACC cycle
    start_op(9, 9, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_ready", 32'(oReady), 32'd1);
    check("midrst_product", 32'(oProduct), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    changes = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (oValid) changes++;
    end
    check("midrst_no_valid", 32'(changes), 32'd0);
    run_op("after_rst", 2, 2, 16'd4, 1'b1);

    // Sweep all B against a spread of A, including every d2 value
    for (int ai = 0; ai < 11; ai++) begin
      for (int b = -128; b < 128; b++) begin
        run_op($sformatf("sweep_a%0d_b%0d", a_set[ai], b), a_set[ai], b,
               16'(a_set[ai] * b), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
